// File: rtl/i2c_eeprom_target_pkg.sv
// Shared definitions for the I2C EEPROM target: FSM state encodings, the
// ACK/NACK bus levels, the R/W bit position and the bus-event bundle produced
// by the synchronizer.
package i2c_eeprom_target_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StDevAddr  = 3'd1;
  localparam state_t StWordAddr = 3'd2;
  localparam state_t StWrData   = 3'd3;
  localparam state_t StRdData   = 3'd4;
  localparam state_t StRdAck    = 3'd5;
  localparam state_t StIgnore   = 3'd6;

  // SDA level that means ACK / NACK on the bus.
  localparam logic AckBit  = 1'b0;
  localparam logic NackBit = 1'b1;

  // Position of the R/W flag in the address byte (1 = read).
  localparam int unsigned RwBit = 0;

  // Single-cycle bus events in the aclk domain.
  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
  } bus_evt_t;

  // Increment the low page_bits of ptr with wrap; upper bits are kept.
  function automatic logic [7:0] page_inc(input logic [7:0] ptr, input int unsigned page_bits);
    logic [7:0] mask;
    mask = 8'((32'd1 << page_bits) - 32'd1);
    return (ptr & ~mask) | ((ptr + 8'd1) & mask);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the aclk domain and derives bus events.
// Ports:
//   clk_i   system clock (aclk)
//   rst_i   synchronous active-high reset
//   scl_i   raw SCL level (asynchronous)
//   sda_i   raw SDA level (asynchronous)
//   sda_o   synchronized SDA level, aligned with evt_o
//   evt_o   scl_rise / scl_fall / start / stop single-cycle pulses
module i2c_bus_sync
  import i2c_eeprom_target_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     scl_i,
  input  logic     sda_i,
  output logic     sda_o,
  output bus_evt_t evt_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the idle bus level so leaving reset does not fake an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    sda_o          = sda_s;
    evt_o.scl_rise = scl_s & ~scl_prev_q;
    evt_o.scl_fall = ~scl_s & scl_prev_q;
    // SCL must be high on both samples so an SCL edge is never taken as START/STOP.
    evt_o.start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    evt_o.stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  end

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating an AT24C02-style 256x8 EEPROM: random/current-address
// reads, byte/page writes and an optional write-cycle busy window.
// Ports:
//   aclk     system clock, >= 16x SCL
//   areset   synchronous active-high reset
//   scl_i    SCL bus level (async)
//   sda_i    SDA bus level (async)
//   sda_oe   1 = pull SDA low
//   busy     write cycle in progress; device address is NACKed
//   wr_evt   one-cycle pulse per byte committed to memory
//   wr_addr  address of committed byte
//   wr_data  committed byte
module i2c_eeprom_target
  import i2c_eeprom_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned PAGE_BITS   = 3,
  parameter int unsigned TWR_CYCLES  = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_evt,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int unsigned TwrW = (TWR_CYCLES > 0) ? $clog2(TWR_CYCLES + 1) : 1;

  bus_evt_t evt;
  logic     sda_s;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(aclk),
    .rst_i(areset),
    .scl_i(scl_i),
    .sda_i(sda_i),
    .sda_o(sda_s),
    .evt_o(evt)
  );

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              full_q, full_d;    // 8 bits received, awaiting the ACK fall
  logic              ack_q, ack_d;      // inside the 9th (ACK) bit slot
  logic [7:0]        ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wrote_q, wrote_d;  // a byte was committed since the last STOP
  logic [TwrW-1:0]   twr_q, twr_d;
  logic              wr_evt_q, wr_evt_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              mem_we;
  logic              rx_state;
  logic [7:0]        mem_q [256];

  assign rx_state = (state_q == StDevAddr) || (state_q == StWordAddr) || (state_q == StWrData);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    full_d    = full_q;
    ack_d     = ack_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wrote_d   = wrote_q;
    twr_d     = twr_q;
    wr_evt_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;

    if (twr_q != '0) begin
      twr_d = twr_q - TwrW'(1);
    end

    if (evt.stop) begin
      state_d   = StIdle;
      sda_oe_d  = 1'b0;
      ack_d     = 1'b0;
      full_d    = 1'b0;
      bit_cnt_d = 3'd0;
      wrote_d   = 1'b0;
      if (wrote_q && (TWR_CYCLES > 0)) begin
        twr_d = TwrW'(TWR_CYCLES);
      end
    end else if (evt.start) begin
      state_d   = StDevAddr;
      sda_oe_d  = 1'b0;
      ack_d     = 1'b0;
      full_d    = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (rx_state) begin
      if (evt.scl_rise && !ack_q && !full_q) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          full_d = 1'b1;
        end
      end else if (evt.scl_fall && ack_q) begin
        // End of our ACK slot.
        sda_oe_d = 1'b0;
        ack_d    = 1'b0;
      end else if (evt.scl_fall && full_q) begin
        full_d = 1'b0;
        if (state_q == StDevAddr) begin
          if ((shift_q[7:1] == DEV_ADDR) && (twr_q == '0)) begin
            sda_oe_d = ~AckBit;
            ack_d    = 1'b1;
            state_d  = shift_q[RwBit] ? StRdData : StWordAddr;
          end else begin
            state_d = StIgnore;
          end
        end else if (state_q == StWordAddr) begin
          ptr_d    = shift_q;
          sda_oe_d = ~AckBit;
          ack_d    = 1'b1;
          state_d  = StWrData;
        end else begin
          mem_we    = 1'b1;
          wr_evt_d  = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = shift_q;
          ptr_d     = page_inc(ptr_q, PAGE_BITS);
          wrote_d   = 1'b1;
          sda_oe_d  = ~AckBit;
          ack_d     = 1'b1;
        end
      end
    end else if (state_q == StRdData) begin
      if (evt.scl_fall) begin
        if (ack_q) begin
          // Fall closing the address ACK or master ACK: load and present MSB.
          ack_d     = 1'b0;
          shift_d   = mem_q[ptr_q];
          sda_oe_d  = ~mem_q[ptr_q][7];
          bit_cnt_d = 3'd0;
        end else if (bit_cnt_q == 3'd7) begin
          // Eight bits out. The pointer advances here rather than on the master
          // ACK so a NACKed final byte still leaves it at last-read + 1.
          sda_oe_d  = 1'b0;
          bit_cnt_d = 3'd0;
          ptr_d     = ptr_q + 8'd1;
          state_d   = StRdAck;
        end else begin
          shift_d   = {shift_q[6:0], 1'b0};
          sda_oe_d  = ~shift_q[6];
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
    end else if (state_q == StRdAck) begin
      if (evt.scl_rise) begin
        if (sda_s == NackBit) begin
          state_d = StIgnore;
        end else begin
          state_d = StRdData;
          ack_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      full_q    <= 1'b0;
      ack_q     <= 1'b0;
      ptr_q     <= 8'd0;
      sda_oe_q  <= 1'b0;
      wrote_q   <= 1'b0;
      twr_q     <= '0;
      wr_evt_q  <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      full_q    <= full_d;
      ack_q     <= ack_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wrote_q   <= wrote_d;
      twr_q     <= twr_d;
      wr_evt_q  <= wr_evt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= shift_q;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = (twr_q != '0);
  assign wr_evt  = wr_evt_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Bench for i2c_eeprom_target: an I2C master model drives directed table
// vectors, two hand-written corner sequences and random transactions, checked
// against a byte-array EEPROM model.
module tb_i2c_eeprom_target;

  localparam int Q = 6;  // aclk cycles per SCL quarter period
  localparam logic [1:0] OpWr = 2'd0, OpRrd = 2'd1, OpCrd = 2'd2;

  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  dev;
    logic [7:0]  addr;
    logic [2:0]  n;
    logic [31:0] d;   // byte i at d[8*i +: 8]
    logic        ea;  // expected bus level of every ACK slot
    logic [31:0] rd;  // expected read bytes
  } vec_t;

  logic aclk = 1'b0, areset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, busy, wr_evt, sda_bus;
  logic [7:0] wr_addr, wr_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_eeprom_target #(
    .DEV_ADDR(7'h50),
    .PAGE_BITS(3),
    .TWR_CYCLES(500),
    .SYNC_STAGES(2)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .scl_i(scl_m),
    .sda_i(sda_bus),
    .sda_oe(sda_oe),
    .busy(busy),
    .wr_evt(wr_evt),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 aclk = ~aclk;

  int nvec = 0, nerr = 0;
  logic [15:0] wq[$];
  bit oe_seen = 0, chk_oe = 1;
  logic oe_prev = 0;
  int oe_bad = 0, busy_run = 0, busy_len = 0;

  // Model state.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_ptr = 8'h00;
  logic [7:0] wlist[$];

  always @(negedge aclk) begin
    if (wr_evt) wq.push_back({wr_addr, wr_data});
    if (sda_oe) oe_seen = 1;
    if (chk_oe && (sda_oe !== oe_prev) && scl_m) oe_bad++;
    oe_prev = sda_oe;
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) busy_len = busy_run;
      busy_run = 0;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic bitx(input logic b, output logic s);
    tick(Q); sda_m = b;
    tick(Q); scl_m = 1'b1;
    tick(Q); s = sda_bus;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0;
  endtask

  task automatic stop_c();
    tick(Q); sda_m = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bitx(b[i], s);
    bitx(1'b1, ack);
  endtask

  task automatic rbyte(input logic last, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bitx(1'b1, s);
      b[i] = s;
    end
    bitx(last, s);
  endtask

  task automatic xfer(input vec_t v, output logic [7:0] acks, output logic [31:0] rd,
                      output int nb);
    logic a;
    logic [7:0] b;
    acks = 8'hFF; rd = '0; nb = 0;
    start_c();
    if (v.op == OpCrd) begin
      wbyte(v.dev | 8'h01, a); acks[nb++] = a;
    end else begin
      wbyte(v.dev & 8'hFE, a); acks[nb++] = a;
      wbyte(v.addr, a); acks[nb++] = a;
      if (v.op == OpWr) begin
        for (int i = 0; i < int'(v.n); i++) begin
          wbyte(v.d[8*i +: 8], a); acks[nb++] = a;
        end
      end else begin
        start_c();
        wbyte(v.dev | 8'h01, a); acks[nb++] = a;
      end
    end
    if (v.op != OpWr) begin
      for (int i = 0; i < int'(v.n); i++) begin
        rbyte(i == int'(v.n) - 1, b);
        rd[8*i +: 8] = b;
      end
    end
    stop_c();
  endtask

  task automatic wait_busy_done();
    int k = 0;
    while (busy && k < 1000) begin
      tick(1);
      k++;
    end
    check("busy_clear", busy, 0);
    tick(3);
    check("busy_len", busy_len, 500);
  endtask

  task automatic apply(input vec_t v, input bit directed, input bit skip_busy);
    logic [7:0] acks, a, eb;
    logic [31:0] rd;
    logic [15:0] exp_w[$];
    int nb;
    bit match;
    logic ea;
    match = (v.dev[7:1] == 7'h50);
    ea = directed ? v.ea : !match;
    wq.delete();
    oe_seen = 0;
    xfer(v, acks, rd, nb);
    for (int i = 0; i < nb; i++) check($sformatf("ack[%0d] op%0d", i, v.op), acks[i], ea);
    if (v.op != OpWr && match) begin
      a = (v.op == OpRrd) ? v.addr : m_ptr;
      for (int i = 0; i < int'(v.n); i++) begin
        if (directed) check($sformatf("rd[%0d] @%02h", i, a), rd[8*i +: 8], v.rd[8*i +: 8]);
        else if (m_known[a]) check($sformatf("rd[%0d] @%02h", i, a), rd[8*i +: 8], m_mem[a]);
        a = a + 8'd1;
      end
      m_ptr = a;
    end
    if (v.op == OpWr && match) begin
      a = v.addr;
      for (int i = 0; i < int'(v.n); i++) begin
        eb = v.d[8*i +: 8];
        m_mem[a] = eb;
        m_known[a] = 1;
        wlist.push_back(a);
        exp_w.push_back({a, eb});
        a = (a & 8'hF8) | ((a + 8'd1) & 8'h07);
      end
      m_ptr = a;
    end
    check("wr_evt count", wq.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
      check($sformatf("wr_evt[%0d] {addr,data}", i), wq[i], exp_w[i]);
    if (!match) check("sda_oe quiet", oe_seen, 0);
    if (!skip_busy) begin
      if (v.op == OpWr && match && v.n != 0) begin
        check("busy set", busy, 1);
        wait_busy_done();
      end else begin
        check("busy idle", busy, 0);
      end
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] dev, input logic [7:0] addr,
                              input logic [2:0] n, input logic [31:0] d, input logic ea,
                              input logic [31:0] rd);
    vec_t v;
    v.op = op; v.dev = dev; v.addr = addr; v.n = n; v.d = d; v.ea = ea; v.rd = rd;
    return v;
  endfunction

  initial begin
    vec_t vecs[11];
    vec_t v;
    logic s, a;
    logic [7:0] b;
    logic [7:0] acks;
    logic [31:0] rd;
    int nb;

    for (int i = 0; i < 256; i++) m_known[i] = 0;

    vecs[0]  = mk(OpWr,  8'hA0, 8'h10, 3'd2, 32'h00003CA5, 1'b0, 32'h0);
    vecs[1]  = mk(OpRrd, 8'hA0, 8'h10, 3'd2, 32'h0,        1'b0, 32'h00003CA5);
    vecs[2]  = mk(OpWr,  8'hA2, 8'h10, 3'd1, 32'h00000055, 1'b1, 32'h0);
    vecs[3]  = mk(OpWr,  8'hA0, 8'hFF, 3'd1, 32'h0000009C, 1'b0, 32'h0);
    vecs[4]  = mk(OpWr,  8'hA0, 8'h06, 3'd3, 32'h00332211, 1'b0, 32'h0);
    vecs[5]  = mk(OpRrd, 8'hA0, 8'h06, 3'd2, 32'h0,        1'b0, 32'h00002211);
    vecs[6]  = mk(OpRrd, 8'hA0, 8'hFF, 3'd2, 32'h0,        1'b0, 32'h0000339C);
    vecs[7]  = mk(OpWr,  8'hA0, 8'h07, 3'd0, 32'h0,        1'b0, 32'h0);
    vecs[8]  = mk(OpCrd, 8'hA1, 8'h00, 3'd1, 32'h0,        1'b0, 32'h00000022);
    vecs[9]  = mk(OpRrd, 8'hA0, 8'hFF, 3'd1, 32'h0,        1'b0, 32'h0000009C);
    vecs[10] = mk(OpCrd, 8'hA1, 8'h00, 3'd1, 32'h0,        1'b0, 32'h00000033);

    // Reset values.
    tick(3);
    check("reset sda_oe", sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset wr_evt", wr_evt, 0);
    check("reset wr_addr", wr_addr, 0);
    check("reset wr_data", wr_data, 0);
    areset = 1'b0;
    tick(4);

    for (int i = 0; i < 11; i++) apply(vecs[i], 1'b1, 1'b0);

    // Busy window: address is NACKed right after a write STOP.
    apply(mk(OpWr, 8'hA0, 8'h20, 3'd1, 32'h0000005A, 1'b0, 32'h0), 1'b1, 1'b1);
    check("busy after write", busy, 1);
    start_c();
    wbyte(8'hA1, a);
    check("nack while busy", a, 1);
    check("busy during nack", busy, 1);
    stop_c();
    wait_busy_done();
    apply(mk(OpRrd, 8'hA0, 8'h20, 3'd1, 32'h0, 1'b0, 32'h0000005A), 1'b1, 1'b0);

    // Reset during bit 4 of a read of 0x22 (bit 4 is 0, so SDA is being pulled).
    start_c();
    wbyte(8'hA0, a); check("rst seq ack dev", a, 0);
    wbyte(8'h07, a); check("rst seq ack addr", a, 0);
    start_c();
    wbyte(8'hA1, a); check("rst seq ack rd", a, 0);
    for (int i = 0; i < 3; i++) begin
      bitx(1'b1, s);
      b[i] = s;
    end
    check("rst seq first bits", {5'd0, b[0], b[1], b[2]}, 32'h1);
    tick(Q); tick(Q); scl_m = 1'b1; tick(Q);
    check("sda_oe before reset", sda_oe, 1);
    chk_oe = 0;
    areset = 1'b1;
    tick(1);
    check("sda_oe after reset", sda_oe, 0);
    areset = 1'b0;
    m_ptr = 8'h00;
    tick(Q); scl_m = 1'b0;
    tick(2);
    chk_oe = 1;
    apply(mk(OpCrd, 8'hA1, 8'h00, 3'd1, 32'h0, 1'b0, 32'h00000033), 1'b1, 1'b0);

    // Random transactions against the model.
    for (int t = 0; t < 20; t++) begin
      v.op   = (wlist.size() == 0) ? OpWr : 2'($urandom_range(0, 2));
      v.dev  = 8'hA0;
      v.addr = 8'($urandom);
      v.d    = $urandom;
      v.ea   = 1'b0;
      v.rd   = '0;
      if (v.op == OpWr) begin
        v.n = 3'($urandom_range(0, 4));
        if ($urandom_range(0, 5) == 0) v.dev = {7'h50 ^ 7'($urandom_range(1, 127)), 1'b0};
      end else begin
        v.n = 3'($urandom_range(1, 4));
        v.addr = wlist[$urandom_range(0, wlist.size() - 1)];
        if (v.op == OpCrd) v.dev = 8'hA1;
      end
      apply(v, 1'b0, 1'b0);
    end

    check("sda_oe moved only while SCL low", oe_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
